// File: rtl/fifo_rd_unpack_pkg.sv
// Shared types and elaboration helpers for the sync_fifo read-side unpacker.
package fifo_rd_unpack_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  localparam buf_cnt_t BUF_FULL = 2'd2;

  // Buffer operation encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } buf_op_e;

  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic bit width_ok(input int dw, input int ow);
    return (ow > 0) && (dw >= ow) && ((dw % ow) == 0);
  endfunction

endpackage

// File: rtl/unpack_word_buf.sv
// Two-entry FIFO-ordered word buffer; head is always the oldest word.
module unpack_word_buf
  import fifo_rd_unpack_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output buf_cnt_t      count,
  output logic [DW-1:0] head
);

  buf_cnt_t      count_q;
  logic [DW-1:0] head_word;
  logic [DW-1:0] tail_word;
  buf_op_e       op;

  assign op    = buf_op_e'({push, pop});
  assign count = count_q;
  assign head  = head_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      head_word <= '0;
      tail_word <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (count_q == 2'd0) head_word <= push_data;
          else                 tail_word <= push_data;
          if (count_q != BUF_FULL) count_q <= count_q + 2'd1;
        end
        OP_POP: begin
          head_word <= tail_word;
          if (count_q != 2'd0) count_q <= count_q - 2'd1;
        end
        OP_SWAP: begin
          // Count is unchanged; the new word lands wherever the popped slot leaves room.
          if (count_q == BUF_FULL) begin
            head_word <= tail_word;
            tail_word <= push_data;
          end else begin
            head_word <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_unpack.sv
// Reads words from sync_fifo through a 2-word prefetch buffer and emits them as
// LSB-first OW-bit beats on a valid/ready stream.
module fifo_rd_unpack
  import fifo_rd_unpack_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          fifo_ren,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_rempty,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int RATIO = DW / OW;
  localparam int IW    = idx_width(RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  if (!width_ok(DW, OW)) begin : g_bad_width
    $error("fifo_rd_unpack: DW must be a non-zero integer multiple of OW");
  end

  buf_cnt_t      count;
  logic [DW-1:0] head;
  logic          inflight;
  logic [IW-1:0] idx;
  logic [OW-1:0] beat_sel;
  logic          accept;
  logic          pop;
  logic          push;
  logic [2:0]    occupancy;

  unpack_word_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (fifo_rdata),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  if (RATIO == 1) begin : g_pass
    assign beat_sel = head;
  end else begin : g_mux
    logic [OW-1:0] beats [RATIO];
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_beat
      assign beats[gi] = head[gi*OW +: OW];
    end
    assign beat_sel = beats[idx];
  end

  assign out_valid = (count != 2'd0);
  assign out_last  = out_valid & (idx == LAST_IDX);
  assign out_data  = out_valid ? beat_sel : '0;
  assign busy      = out_valid | inflight;

  assign accept = out_valid & out_ready;
  assign pop    = accept & out_last;
  // rdata is only meaningful the cycle after a read; flush drops that word.
  assign push   = inflight & ~flush;

  // Words held or owed after this cycle; a pop this cycle frees a slot early,
  // which is what sustains one beat per cycle at RATIO=1.
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
  assign fifo_ren  = ~rst & ~fifo_rempty & ~flush & (occupancy < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      idx      <= '0;
    end else if (flush) begin
      inflight <= 1'b0;
      idx      <= '0;
    end else begin
      inflight <= fifo_ren;
      if (accept) idx <= out_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Scoreboard bench: two unpacker instances (32->8 and 32->32) fed by sync_fifo models.
module tb_fifo_rd_unpack;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_ren, a_rempty, a_flush, a_valid, a_ready, a_last, a_busy;
  logic [31:0] a_rdata = '0;
  logic [7:0]  a_data;
  logic        b_ren, b_rempty, b_flush, b_valid, b_ready, b_last, b_busy;
  logic [31:0] b_rdata = '0;
  logic [31:0] b_data;

  fifo_rd_unpack #(.DW(32), .OW(8)) dut_a (
    .clk(clk), .rst(rst), .fifo_ren(a_ren), .fifo_rdata(a_rdata),
    .fifo_rempty(a_rempty), .flush(a_flush), .out_valid(a_valid),
    .out_ready(a_ready), .out_data(a_data), .out_last(a_last), .busy(a_busy)
  );

  fifo_rd_unpack #(.DW(32), .OW(32)) dut_b (
    .clk(clk), .rst(rst), .fifo_ren(b_ren), .fifo_rdata(b_rdata),
    .fifo_rempty(b_rempty), .flush(b_flush), .out_valid(b_valid),
    .out_ready(b_ready), .out_data(b_data), .out_last(b_last), .busy(b_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sync_fifo models: registered read, rdata holds stale data when not read.
  logic [31:0] a_mem [64];
  logic [31:0] b_mem [64];
  int a_wp = 0, a_rp = 0, a_rerr = 0, a_rens = 0;
  int b_wp = 0, b_rp = 0, b_rerr = 0, b_rens = 0;

  assign a_rempty = (a_wp == a_rp);
  assign b_rempty = (b_wp == b_rp);

  always @(posedge clk) begin
    if (a_ren) begin
      a_rens <= a_rens + 1;
      if (a_wp == a_rp) a_rerr <= a_rerr + 1;
      else begin
        a_rdata <= a_mem[a_rp];
        a_rp    <= a_rp + 1;
      end
    end
    if (b_ren) begin
      b_rens <= b_rens + 1;
      if (b_wp == b_rp) b_rerr <= b_rerr + 1;
      else begin
        b_rdata <= b_mem[b_rp];
        b_rp    <= b_rp + 1;
      end
    end
  end

  beat_t a_exp [$];
  beat_t b_exp [$];
  int    a_cyc [$];
  int    b_cyc [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input logic [7:0] d, input logic l);
    a_exp.push_back('{data: {24'h0, d}, last: l});
  endtask

  task automatic load_a(input logic [31:0] w, input bit emit);
    a_mem[a_wp] = w;
    a_wp++;
    if (emit)
      for (int k = 0; k < 4; k++) expect_a(w[k*8 +: 8], k == 3);
  endtask

  task automatic load_b(input logic [31:0] w);
    b_mem[b_wp] = w;
    b_wp++;
    b_exp.push_back('{data: w, last: 1'b1});
  endtask

  task automatic drain_a(input string name);
    for (int i = 0; i < 200 && a_exp.size() != 0; i++) step();
    chk(name, 32'(a_exp.size()), 32'd0);
    repeat (3) step();
  endtask

  task automatic drain_b(input string name);
    for (int i = 0; i < 200 && b_exp.size() != 0; i++) step();
    chk(name, 32'(b_exp.size()), 32'd0);
    repeat (3) step();
  endtask

  // Counts cycles (sampled at negedge) where stream A shows any activity.
  task automatic idle_a(input string name, input int n);
    int viol;
    viol = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_ren || a_valid || a_busy) viol++;
    end
    chk(name, 32'(viol), 32'd0);
  endtask

  initial begin
    fork
      begin : stim
        int n0, base, ren0;
        rst = 1'b1;
        a_ready = 1'b0; a_flush = 1'b0;
        b_ready = 1'b0; b_flush = 1'b0;
        step(); step();
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_last",  32'(a_last),  32'd0);
        chk("rst_a_data",  32'(a_data),  32'd0);
        chk("rst_a_busy",  32'(a_busy),  32'd0);
        chk("rst_a_ren",   32'(a_ren),   32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_b_data",  b_data,       32'd0);
        rst = 1'b0;
        step();

        // Two words, continuous ready: eight back-to-back beats.
        a_ready = 1'b1;
        n0 = cyc; base = a_cyc.size(); ren0 = a_rens;
        load_a(32'h4433_2211, 1'b1);
        load_a(32'h8877_6655, 1'b1);
        drain_a("t1_drain");
        chk("t1_count", 32'(a_cyc.size() - base), 32'd8);
        if (a_cyc.size() >= base + 8) begin
          chk("t1_first_cycle", 32'(a_cyc[base]),     32'(n0 + 2));
          chk("t1_last_cycle",  32'(a_cyc[base + 7]), 32'(n0 + 9));
        end
        chk("t1_ren_pulses", 32'(a_rens - ren0), 32'd2);

        // RATIO=1 pass-through: 16 words, no bubbles.
        b_ready = 1'b1;
        n0 = cyc; base = b_cyc.size();
        for (int i = 0; i < 16; i++) load_b(32'hA5A5_0000 + 32'(i * 32'h0101));
        drain_b("b_drain");
        chk("b_count", 32'(b_cyc.size() - base), 32'd16);
        if (b_cyc.size() >= base + 16) begin
          chk("b_first_cycle", 32'(b_cyc[base]),      32'(n0 + 2));
          chk("b_last_cycle",  32'(b_cyc[base + 15]), 32'(n0 + 17));
        end

        // Empty FIFO with ready high: nothing moves.
        idle_a("empty_idle", 20);

        // Backpressure on the first beat.
        a_ready = 1'b0;
        ren0 = a_rens; base = a_cyc.size();
        load_a(32'h4433_2211, 1'b1);
        load_a(32'h8877_6655, 1'b1);
        load_a(32'hCCBB_AA99, 1'b1);
        for (int i = 0; i < 20 && !a_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_valid", 32'(a_valid), 32'd1);
          chk("bp_data",  32'(a_data),  32'h11);
          chk("bp_last",  32'(a_last),  32'd0);
        end
        chk("bp_ren_pulses", 32'(a_rens - ren0), 32'd2);
        step();
        a_ready = 1'b1;
        drain_a("bp_drain");
        chk("bp_count", 32'(a_cyc.size() - base), 32'd12);
        if (a_cyc.size() >= base + 12)
          chk("bp_no_bubble", 32'(a_cyc[base + 11] - a_cyc[base]), 32'd11);

        // Flush while the next word is in flight: 33/44 and the returning word vanish.
        a_ready = 1'b1;
        n0 = cyc;
        load_a(32'h4433_2211, 1'b0);
        expect_a(8'h11, 1'b0);
        expect_a(8'h22, 1'b0);
        step(); step(); step();
        load_a(32'h8877_6655, 1'b0);
        step();
        a_flush = 1'b1;
        a_ready = 1'b0;
        step();
        a_flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(a_valid), 32'd0);
        chk("flush_busy",  32'(a_busy),  32'd0);
        chk("flush_word_was_read", 32'(a_wp - a_rp), 32'd0);
        chk("flush_exp_empty", 32'(a_exp.size()), 32'd0);
        idle_a("flush_idle", 3);
        step();
        a_ready = 1'b1;
        n0 = cyc; base = a_cyc.size();
        load_a(32'hDDCC_BBAA, 1'b1);
        drain_a("flush_drain");
        if (a_cyc.size() > base)
          chk("flush_restart_cycle", 32'(a_cyc[base]), 32'(n0 + 2));

        // Asynchronous reset mid-word, after beat 33.
        load_a(32'h4433_2211, 1'b0);
        expect_a(8'h11, 1'b0);
        expect_a(8'h22, 1'b0);
        expect_a(8'h33, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_data",  32'(a_data),  32'd0);
        chk("arst_last",  32'(a_last),  32'd0);
        chk("arst_busy",  32'(a_busy),  32'd0);
        chk("arst_ren",   32'(a_ren),   32'd0);
        step(); step();
        rst = 1'b0;
        chk("arst_exp_empty", 32'(a_exp.size()), 32'd0);
        idle_a("arst_idle", 3);
        step();
        n0 = cyc; base = a_cyc.size();
        load_a(32'hDDCC_BBAA, 1'b1);
        drain_a("arst_drain");
        if (a_cyc.size() > base)
          chk("arst_restart_cycle", 32'(a_cyc[base]), 32'(n0 + 2));

        chk("rerr_a", 32'(a_rerr), 32'd0);
        chk("rerr_b", 32'(b_rerr), 32'd0);
      end
      begin : mon_a
        beat_t e;
        forever begin
          @(negedge clk);
          if (!rst && a_valid && a_ready) begin
            a_cyc.push_back(cyc);
            if (a_exp.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL beat_a: got data %h last %0d, want no beat", a_data, a_last);
            end else begin
              e = a_exp.pop_front();
              chk("beat_a", {23'h0, a_last, a_data}, {23'h0, e.last, e.data[7:0]});
            end
          end
        end
      end
      begin : mon_b
        beat_t e;
        forever begin
          @(negedge clk);
          if (!rst && b_valid && b_ready) begin
            b_cyc.push_back(cyc);
            if (b_exp.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL beat_b: got data %h last %0d, want no beat", b_data, b_last);
            end else begin
              e = b_exp.pop_front();
              chk("beat_b_data", b_data, e.data);
              chk("beat_b_last", 32'(b_last), 32'(e.last));
            end
          end
        end
      end
      begin : watchdog
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_unpack.md
Name: fifo_rd_unpack

Overview:
Read-side consumer placed directly downstream of sync_fifo. It drives the FIFO's ren/rdata/rempty read interface, hides the FIFO's 1-cycle registered-read latency with a 2-word prefetch buffer, and unpacks each DW-bit word into DW/OW narrow beats on a valid/ready stream. It feeds narrow-datapath consumers such as PE-array operand loaders.

Parameters:
DW, 32, FIFO word width; must equal the sync_fifo DW.
OW, 8, output beat width; DW must be an integer multiple of OW.
RATIO, DW/OW (localparam), beats per word; RATIO=1 is legal and acts as a pure pass-through.

Ports:
clk  in  1  clock
rst  in  1  reset
fifo_ren  out  1  read strobe to sync_fifo ren
fifo_rdata  in  DW  sync_fifo rdata; valid the cycle after fifo_ren
fifo_rempty  in  1  sync_fifo rempty
flush  in  1  synchronous clear of buffered and in-flight data
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_data  out  OW  current beat
out_last  out  1  beat is the last (RATIO-1) of its word
busy  out  1  buffer non-empty or read in flight

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. While rst is high:
  - buffer count = 0, in-flight flag = 0, beat index = 0.
  - out_valid = 0, out_last = 0, out_data = 0, busy = 0, fifo_ren = 0.
- Reset mid-operation discards all buffered and in-flight words. No beat is emitted after rst deasserts until a new FIFO read completes.
- Word buffer: 2 entries, FIFO-ordered. State is buf_cnt (0..2) plus an in-flight flag (ren issued in the previous cycle).
- Word pop: occurs when out_valid & out_ready & out_last.
- fifo_ren issue rule:
  - Asserted when ~fifo_rempty & ~flush & (buf_cnt + inflight - pop) < 2.
  - Combinational from out_ready and fifo_rempty. This path is permitted because the FIFO registers ren internally.
- fifo_ren is never asserted while fifo_rempty=1, so the FIFO's rerr never fires because of this block.
- Capture: when the in-flight flag is set, fifo_rdata is written into the buffer tail at the clock edge. fifo_rdata is ignored in every other cycle, because the FIFO holds stale data.
- Capture and pop in the same cycle: buf_cnt is unchanged and the entries shift correctly.
- Latency: block idle, FIFO becomes non-empty in cycle 0 → fifo_ren in cycle 0, rdata valid in cycle 1, captured at the end of cycle 1, out_valid=1 in cycle 2.
- Throughput: one beat per cycle sustained under continuous out_ready with a non-empty FIFO, for any RATIO including 1.
- Unpacking:
  - Beat k = head word [k*OW +: OW], LSB-first.
  - The beat index increments on each accepted beat and wraps from RATIO-1 to 0 on pop.
  - out_last = (index == RATIO-1).
- Output stability: while out_valid=1 & out_ready=0, out_data and out_last hold stable, and no beat is skipped or repeated.
- flush (synchronous, single cycle or held):
  - buf_cnt, the in-flight flag and the beat index are cleared. An in-flight word that returns the next cycle is dropped.
  - out_valid=0 from the next cycle.
  - fifo_ren is forced 0 while flush=1.
  - flush has priority over capture and pop in the same cycle.
- busy = (buf_cnt != 0) | inflight.

Decomposition:
- Shared package: beat-index width function $clog2(RATIO) (minimum 1) and an elaboration-time check that DW % OW == 0.
- One natural sub-module, unpack_word_buf: the 2-entry word buffer with push/pop/clear, count, and head output. The top level holds the issue logic, in-flight flag, beat index and mux.

Test Plan:
- DW=32, OW=8; FIFO holds 0x44332211, 0x88776655; out_ready=1 → beats 11,22,33,44,55,66,77,88 on consecutive cycles; out_last on 44 and 88; first out_valid 2 cycles after fifo_rempty falls; exactly 2 fifo_ren pulses.
- DW=OW=32 (RATIO=1); 16 words pre-loaded; out_ready=1 → 16 beats in cycles 2..17 with no bubbles; every beat has out_last=1.
- Backpressure: out_ready=0 for 5 cycles while the first beat 0x11 is valid → out_data stays 0x11; fifo_ren pulses at most twice total (buf_cnt saturates at 2); after release the stream resumes with 22,33,44,... and no loss.
- Empty FIFO: fifo_rempty=1 held for 20 cycles → fifo_ren=0, out_valid=0, busy=0 throughout; FIFO rerr never asserts.
- flush asserted after beat 0x22 is accepted, in the same cycle a read is in flight → next cycle out_valid=0 and busy=0; the returning word is not emitted; the next FIFO word 0xDDCCBBAA emits starting at 0xAA with index 0.
- rst pulsed mid-word, after beat 0x33 → all outputs 0 immediately (asynchronous); after release with a reloaded FIFO, the output restarts cleanly at beat 0 of the new word.
